// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a registered-read FIFO into a 2-entry valid/ready stream buffer and marks burst ends.
// Optional feature: define FIFO_RD_STREAM_STATS_EN to add the 32-bit stat_beats_o delivered-beat counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  flush_i
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           stat_beats_o
`endif
);

  localparam int               CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                state;
  logic [1:0]            occ;
  logic                  infl;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  pop;
  logic                  capture;
  logic [2:0]            pending;

  assign pop     = m_valid_o && m_ready_i;
  assign capture = infl && (state == RUN) && !flush_i;

  // Words that will sit in the buffer once this cycle's pop and the in-flight read settle.
  assign pending = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};

  assign fifo_rd_en_o = !rst_i && !fifo_empty_i && !flush_i && (state == RUN) && (pending < 3'd2);
  assign m_valid_o    = (occ != 2'd0);
  assign m_data_o     = entry0;
  assign m_last_o     = m_valid_o && (count == CNT_MAX);

  // NOTE: every register here uses <= so all of them sample the pre-edge values of pop/capture/occ.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= RUN;
      occ    <= 2'd0;
      infl   <= 1'b0;
      count  <= '0;
      // NOTE: the data entries are reset as well, because m_data_o must read 0 while rst_i is high.
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      infl <= fifo_rd_en_o;
      if (flush_i) begin
        occ   <= 2'd0;
        count <= '0;
        state <= infl ? DRAIN : RUN;
      end else begin
        state <= RUN;
        if (pop) count <= (count == CNT_MAX) ? '0 : count + 1'b1;
        unique case ({pop, capture})
          2'b10: begin
            entry0 <= entry1;
            occ    <= occ - 2'd1;
          end
          2'b01: begin
            if (occ == 2'd0) entry0 <= fifo_rd_data_i;
            else             entry1 <= fifo_rd_data_i;
            occ <= occ + 2'd1;
          end
          2'b11: begin
            // Shift and append together; occupancy is unchanged.
            if (occ == 2'd1) begin
              entry0 <= fifo_rd_data_i;
            end else begin
              entry0 <= entry1;
              entry1 <= fifo_rd_data_i;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  // Counts every delivered beat, including one delivered in a flush cycle; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    stat_beats_o <= '0;
    else if (pop) stat_beats_o <= stat_beats_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-based reference model of the read streamer, checked every cycle,
// plus directed bursts with literal expectations and a randomized phase.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int BL = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic [DW-1:0] fifo_rd_data_i = '0;
  logic          fifo_rd_en_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          flush_i = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]   stat_beats_o;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_data_o       (m_data_o),
    .m_last_o       (m_last_o),
    .flush_i        (flush_i)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stat_beats_o   (stat_beats_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Environment FIFO contents and the expected delivery order.
  logic [DW-1:0] env_q[$];
  logic [DW-1:0] exp_q[$];

  // Reference model: buffered words, in-flight flag, drain flag, beat position, delivered total.
  logic [DW-1:0] mq[$];
  bit            m_infl;
  bit            m_drain;
  int            m_cnt;
  logic [31:0]   m_stat;

  // Observations from the DUT.
  logic [DW-1:0] beat_d[$];
  bit            beat_l[$];
  int            beat_c[$];
  int            rd_count;
  int            first_rd_cyc;
  int            empty_viol = 0;
  bit            rd_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl  = 1'b0;
    m_drain = 1'b0;
    m_cnt   = 0;
    m_stat  = '0;
  endtask

  task automatic clear_logs();
    beat_d.delete();
    beat_l.delete();
    beat_c.delete();
    exp_q.delete();
    rd_count     = 0;
    first_rd_cyc = -1;
  endtask

  task automatic fill_seq(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      env_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
    fifo_empty_i = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom();
      env_q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_empty_i = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then let the FIFO respond.
  task automatic tick();
    bit            e_valid, e_last, e_pop, e_rd;
    logic [DW-1:0] e_data;
    @(negedge clk_i);
    if (!rst_i) begin
      e_valid = mq.size() > 0;
      e_data  = e_valid ? mq[0] : '0;
      e_last  = e_valid && (m_cnt == BL - 1);
      e_pop   = e_valid && m_ready_i;
      e_rd    = !fifo_empty_i && !flush_i && !m_drain && ((mq.size() + int'(m_infl) - int'(e_pop)) < 2);
      check("rd_en", fifo_rd_en_o, e_rd);
      check("valid", m_valid_o, e_valid);
      check("last", m_last_o, e_last);
      if (e_valid) check("data", m_data_o, e_data);
`ifdef FIFO_RD_STREAM_STATS_EN
      check("stat", stat_beats_o, m_stat);
`endif
      if (fifo_rd_en_o) begin
        rd_count++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (fifo_empty_i) empty_viol++;
      end
      if (m_valid_o && m_ready_i) begin
        beat_d.push_back(m_data_o);
        beat_l.push_back(m_last_o);
        beat_c.push_back(cyc);
      end
      if (e_pop) m_stat = m_stat + 32'd1;
      if (flush_i) begin
        mq.delete();
        m_cnt   = 0;
        m_drain = m_infl;
      end else begin
        if (e_pop) begin
          mq.delete(0);
          m_cnt = (m_cnt + 1) % BL;
        end
        if (m_infl && !m_drain) mq.push_back(fifo_rd_data_i);
        m_drain = 1'b0;
      end
      m_infl = e_rd;
    end else begin
      model_reset();
    end
    rd_s = fifo_rd_en_o && !rst_i;
    @(posedge clk_i);
    #1;
    cyc++;
    if (rd_s && env_q.size() > 0) fifo_rd_data_i = env_q.pop_front();
    else                          fifo_rd_data_i = $urandom();
    fifo_empty_i = (env_q.size() == 0);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (beat_d.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_beats_in_budget"}, beat_d.size() >= n, 1'b1);
  endtask

  // Delivered words must match the expected order, with last on every BL-th beat.
  task automatic check_burst(input string tag, input int n);
    check({tag, "_count"}, beat_d.size(), n);
    for (int i = 0; i < n && i < beat_d.size(); i++) begin
      check({tag, "_data"}, beat_d[i], exp_q[i]);
      check({tag, "_last"}, beat_l[i], (i % BL) == BL - 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, m_valid_o, 1'b0);
    check({tag, "_last"}, m_last_o, 1'b0);
    check({tag, "_data"}, m_data_o, '0);
    check({tag, "_rd_en"}, fifo_rd_en_o, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check({tag, "_stat"}, stat_beats_o, '0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_logs();
    #1 rst_i = 1'b1;
    #1;
    check_reset_outputs("rst0");

    // Eight words at full rate: latency 2, back-to-back beats, last on 0xA7.
    fill_seq(32'hA0, 8);
    #1;
    check("rst_rd_en_blocked", fifo_rd_en_o, 1'b0);
    tick();
    tick();
    rst_i     = 1'b0;
    m_ready_i = 1'b1;
    wait_beats("s1", 8, 40);
    check_burst("s1", 8);
    if (beat_c.size() > 0) check("s1_latency", beat_c[0] - first_rd_cyc, 2);
    for (int i = 1; i < beat_c.size(); i++) check("s1_consecutive", beat_c[i] - beat_c[i-1], 1);

    // Ready held low for 5 cycles: exactly two reads, head word held.
    clear_logs();
    m_ready_i = 1'b0;
    fill_seq(32'hA0, 8);
    repeat (5) tick();
    check("s2_rd_pulses", rd_count, 2);
    check("s2_valid_held", m_valid_o, 1'b1);
    check("s2_data_held", m_data_o, 32'hA0);
    m_ready_i = 1'b1;
    wait_beats("s2", 8, 40);
    check_burst("s2", 8);

    // Ready toggling over 16 words.
    clear_logs();
    fill_rand(16);
    begin
      int k = 0;
      while (beat_d.size() < 16 && k < 200) begin
        m_ready_i = (k % 2 == 0);
        tick();
        k++;
      end
    end
    check_burst("s3", 16);
    check("s3_rd_while_empty", empty_viol, 0);

    // Flush mid-burst with one buffered and one in-flight word.
    clear_logs();
    m_ready_i = 1'b1;
    fill_seq(32'hD0, 3);
    wait_beats("s4_pre", 3, 30);
    clear_logs();
    m_ready_i = 1'b0;
    fill_seq(32'hC0, 10);
    tick();
    tick();
    check("s4_pre_valid", m_valid_o, 1'b1);
    check("s4_pre_data", m_data_o, 32'hC0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("s4_flush_valid", m_valid_o, 1'b0);
    check("s4_drain_rd_en", fifo_rd_en_o, 1'b0);
    exp_q.delete(0);
    exp_q.delete(0);
    m_ready_i = 1'b1;
    wait_beats("s4", 8, 40);
    check_burst("s4", 8);

    // Reset at beat count 3, then a fresh burst.
    clear_logs();
    fill_seq(32'hE0, 8);
    wait_beats("s5_pre", 3, 30);
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("s5_rst");
    env_q.delete();
    fifo_empty_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    clear_logs();
    fill_seq(32'hF0, 8);
    wait_beats("s5", 8, 40);
    check_burst("s5", 8);

    // Randomized traffic with occasional flushes and refills.
    for (int k = 0; k < 3000; k++) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      flush_i   = ($urandom_range(0, 31) == 0);
      if (env_q.size() < 4 && $urandom_range(0, 3) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 6)); j++) env_q.push_back($urandom());
        fifo_empty_i = 1'b0;
      end
      tick();
    end
    flush_i = 1'b0;
    check("rand_rd_while_empty", empty_viol, 0);

`ifdef FIFO_RD_STREAM_STATS_EN
    // Twenty delivered beats around one flush.
    env_q.delete();
    fifo_empty_i = 1'b1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_logs();
    m_ready_i = 1'b1;
    fill_rand(10);
    wait_beats("s7a", 10, 60);
    m_ready_i = 1'b0;
    flush_i   = 1'b1;
    tick();
    flush_i   = 1'b0;
    m_ready_i = 1'b1;
    fill_rand(10);
    wait_beats("s7b", 20, 60);
    check("s7_stat_beats", stat_beats_o, 32'd20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
